// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Parity support in uart_tx_fifo is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   // data must arrive zero-extended so the unused upper bits do not disturb the XOR
   function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
      logic p;
      p = ^data;
      case (mode)
         PAR_NONE: return 1'b0;
         PAR_EVEN: return p;
         PAR_ODD:  return ~p;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry whenever !empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end, configurable frame, back-to-back frames.
// Define UART_TX_PARITY_EN to add the parity_mode port and the PARITY state.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | data bits, LSB first, shreg shifts right after each bit
// PARITY | parity bit (only with UART_TX_PARITY_EN and an even/odd mode latched)
// STOP   | stop bit(s) high; pops the next word straight into START if one is queued
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   input  logic [DATA_BITS-1:0]          in_data,
   output logic                          in_ready,
`ifdef UART_TX_PARITY_EN
   input  logic [1:0]                    parity_mode,
`endif
   output logic                          tx,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   tx_state_t            state;
   tx_state_t            state_nxt;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shreg_nxt;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 bit_tick;
   logic                 last_bit;
   logic                 last_stop;
   logic                 tx_nxt;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (in_valid && in_ready),
      .din     (in_data),
      .rd_en   (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign in_ready  = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;
   assign bit_tick  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign last_bit  = (bit_idx == BW'(DATA_BITS - 1));
   assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
   assign tx_done   = (state == STOP) && bit_tick && last_stop;

`ifdef UART_TX_PARITY_EN
   logic [1:0] par_mode;
   logic       par_val;
   logic       par_on;

   assign par_on = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);

   // parity is computed from the whole word at pop time, before shreg starts shifting it away
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_mode <= PAR_NONE;
         par_val  <= 1'b0;
      end else if (pop) begin
         par_mode <= parity_mode;
         par_val  <= parity_bit(9'(fifo_dout), parity_mode);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_tick) state_nxt = DATA;
         end
         DATA: begin
            if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = par_on ? PARITY : STOP;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_tick && last_stop) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shreg_nxt = shreg;
      if (pop) begin
         shreg_nxt = fifo_dout;
      end else if ((state == DATA) && bit_tick && !last_bit) begin
         shreg_nxt = shreg >> 1;
      end
   end

   // tx is registered from the next state so the line changes on the same edge as the state
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = par_val;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         tx    <= tx_nxt;

         if ((state == IDLE) || (state_nxt != state) || bit_tick) baud_cnt <= '0;
         else                                                   baud_cnt <= baud_cnt + CW'(1);

         if (state != DATA)  bit_idx <= '0;
         else if (bit_tick)  bit_idx <= bit_idx + BW'(1);

         if (state != STOP)  stop_idx <= 1'b0;
         else if (bit_tick)  stop_idx <= ~stop_idx;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a default instance (8N1) and a 7-data/2-stop instance.
// Pushed words are queued with their expected framing; per-DUT monitors decode tx and compare.
module tb_uart_tx_fifo;

   localparam int C = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] parity_mode = 2'd0;

   logic       in_valid0 = 1'b0;
   logic [7:0] in_data0 = '0;
   logic       in_ready0, tx0, busy0, tx_done0;
   logic [2:0] fifo_count0;

   logic       in_valid1 = 1'b0;
   logic [6:0] in_data1 = '0;
   logic       in_ready1, tx1, busy1, tx_done1;
   logic [2:0] fifo_count1;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid0),
      .in_data     (in_data0),
      .in_ready    (in_ready0),
`ifdef UART_TX_PARITY_EN
      .parity_mode (parity_mode),
`endif
      .tx          (tx0),
      .busy        (busy0),
      .tx_done     (tx_done0),
      .fifo_count  (fifo_count0)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid1),
      .in_data     (in_data1),
      .in_ready    (in_ready1),
`ifdef UART_TX_PARITY_EN
      .parity_mode (parity_mode),
`endif
      .tx          (tx1),
      .busy        (busy1),
      .tx_done     (tx_done1),
      .fifo_count  (fifo_count1)
   );

   typedef struct {
      logic [8:0] d;
      logic [1:0] m;
   } exp_t;

   exp_t exp0[$];
   exp_t exp1[$];
   int   gaps0[$];

   int n_cmp = 0;
   int n_bad = 0;
   int busy_cyc0 = 0, busy_cyc1 = 0, done_cnt0 = 0, done_cnt1 = 0, viol0 = 0;
   bit run0 = 1'b0, run1 = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic get_tx(input int sel);
      return (sel == 0) ? tx0 : tx1;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 0) ? tx_done0 : tx_done1;
   endfunction
   function automatic logic get_rdy(input int sel);
      return (sel == 0) ? in_ready0 : in_ready1;
   endfunction

   function automatic logic exp_par(input logic [8:0] d, input int dbits, input logic [1:0] m);
      logic p;
      p = 1'b0;
      for (int i = 0; i < dbits; i++) p = p ^ d[i];
      return (m == 2'd2) ? ~p : p;
   endfunction

   // busy cycles counted from the first low start bit until busy drops; tx_done pulses; FIFO flag sanity
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset_n) begin
            if (busy0 && (run0 || !tx0)) begin run0 = 1'b1; busy_cyc0++; end
            else if (!busy0) run0 = 1'b0;
            if (busy1 && (run1 || !tx1)) begin run1 = 1'b1; busy_cyc1++; end
            else if (!busy1) run1 = 1'b0;
            if (tx_done0) done_cnt0++;
            if (tx_done1) done_cnt1++;
            if (fifo_count0 > 3'd4 || in_ready0 != (fifo_count0 != 3'd4)) viol0++;
         end else begin
            run0 = 1'b0;
            run1 = 1'b0;
         end
      end
   end

   task automatic monitor(input int sel, input int dbits, input int sbits);
      exp_t       e;
      logic       b[16];
      int         nb, gap, bad, dbad;
      logic [8:0] rx;
      bit         abort, have;
      gap = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n || get_tx(sel) !== 1'b0) begin
            gap++;
            continue;
         end
         have = (sel == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
         chk($sformatf("frame_expected%0d", sel), int'(have), 1);
         e.d = '0;
         e.m = '0;
         if (have) begin
            if (sel == 0) e = exp0.pop_front();
            else          e = exp1.pop_front();
         end
         if (sel == 0) gaps0.push_back(gap);
         b[0] = 1'b0;
         for (int i = 0; i < dbits; i++) b[1+i] = e.d[i];
         nb = 1 + dbits;
`ifdef UART_TX_PARITY_EN
         if (e.m == 2'd1 || e.m == 2'd2) begin
            b[nb] = exp_par(e.d, dbits, e.m);
            nb++;
         end
`endif
         for (int i = 0; i < sbits; i++) b[nb+i] = 1'b1;
         nb = nb + sbits;
         bad = 0; dbad = 0; rx = '0; abort = 1'b0;
         for (int off = 0; off < nb*C; off++) begin
            if (off > 0) begin
               @(posedge clk);
               #1;
            end
            if (!reset_n) begin
               abort = 1'b1;
               break;
            end
            if (get_tx(sel) !== b[off/C]) bad++;
            if ((off % C) == C/2 && (off/C) >= 1 && (off/C) <= dbits) rx[off/C-1] = get_tx(sel);
            if (get_done(sel) !== (off == nb*C-1)) dbad++;
         end
         if (!abort) begin
            chk($sformatf("rx_data%0d", sel), int'(rx), int'(e.d));
            chk($sformatf("frame_bits%0d", sel), bad, 0);
            chk($sformatf("tx_done_pos%0d", sel), dbad, 0);
         end
         gap = 0;
      end
   endtask

   task automatic push(input int sel, input logic [8:0] d, output int waited);
      exp_t e;
      waited = 0;
      @(negedge clk);
      if (sel == 0) begin in_valid0 = 1'b1; in_data0 = d[7:0]; end
      else          begin in_valid1 = 1'b1; in_data1 = d[6:0]; end
      while (get_rdy(sel) !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (get_rdy(sel) !== 1'b1) begin
         chk("push_ready_timeout", int'(get_rdy(sel)), 1);
         in_valid0 = 1'b0;
         in_valid1 = 1'b0;
         return;
      end
      e.d = d;
      e.m = parity_mode;
      if (sel == 0) exp0.push_back(e);
      else          exp1.push_back(e);
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
   endtask

   task automatic wait_idle(input int sel);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (get_busy(sel) && n < 3000);
      chk("wait_idle_timeout", int'(get_busy(sel)), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int w, ws, g, hits, n;
      logic [7:0] burst[4];
      logic [7:0] fullw[6];
      burst = '{8'h00, 8'hFF, 8'h55, 8'hAA};
      fullw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      fork
         monitor(0, 8, 1);
         monitor(1, 7, 2);
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_tx", int'(tx0), 1);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_tx_done", int'(tx_done0), 0);
      chk("rst_fifo_count", int'(fifo_count0), 0);
      chk("rst_in_ready", int'(in_ready0), 1);

      // single word 0xB7
      busy_cyc0 = 0; done_cnt0 = 0;
      push(0, 9'h0B7, w);
      chk("t1_count_after_push", int'(fifo_count0), 1);
      chk("t1_tx_on_push_edge", int'(tx0), 1);
      @(posedge clk);
      #1;
      chk("t1_tx_fall_next_edge", int'(tx0), 0);
      wait_idle(0);
      chk("t1_busy_cycles", busy_cyc0, 80);
      chk("t1_tx_done_count", done_cnt0, 1);

      // burst of four on consecutive edges
      busy_cyc0 = 0; done_cnt0 = 0; ws = 0;
      gaps0.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, {1'b0, burst[i]}, w);
         ws += w;
      end
      chk("t2_ready_stall", ws, 0);
      wait_idle(0);
      chk("t2_busy_cycles", busy_cyc0, 320);
      chk("t2_tx_done_count", done_cnt0, 4);
      g = (gaps0.size() == 4) ? (gaps0[1] + gaps0[2] + gaps0[3]) : -1;
      chk("t2_interframe_gap", g, 0);

`ifdef UART_TX_PARITY_EN
      parity_mode = 2'd1;
      busy_cyc0 = 0;
      push(0, 9'h007, w);
      wait_idle(0);
      chk("t3_even_frame_cycles", busy_cyc0, 88);
      parity_mode = 2'd2;
      busy_cyc0 = 0;
      push(0, 9'h007, w);
      wait_idle(0);
      chk("t3_odd_frame_cycles", busy_cyc0, 88);
      parity_mode = 2'd0;
`endif

      // 7 data bits, 2 stop bits
      busy_cyc1 = 0; done_cnt1 = 0;
      push(1, 9'h041, w);
      wait_idle(1);
      chk("t4_busy_cycles", busy_cyc1, 80);
      chk("t4_tx_done_count", done_cnt1, 1);

      // full FIFO with producer held off by in_ready
      viol0 = 0;
      for (int i = 0; i < 5; i++) push(0, {1'b0, fullw[i]}, w);
      chk("t6_count_full", int'(fifo_count0), 4);
      chk("t6_ready_low_full", int'(in_ready0), 0);
      n = 0;
      while (fifo_count0 == 3'd4 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t6_count_after_pop", int'(fifo_count0), 3);
      chk("t6_ready_after_pop", int'(in_ready0), 1);
      push(0, {1'b0, fullw[5]}, w);
      wait_idle(0);
      chk("t6_flag_violations", viol0, 0);
      chk("t6_drained", exp0.size(), 0);

      // reset during DATA bit 3 with two words queued
      push(0, 9'h0AB, w);
      push(0, 9'h0CD, w);
      push(0, 9'h0EF, w);
      chk("t5_count_queued", int'(fifo_count0), 2);
      repeat (34) @(posedge clk);
      #3;
      chk("t5_busy_before_reset", int'(busy0), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_tx_in_reset", int'(tx0), 1);
      chk("t5_busy_in_reset", int'(busy0), 0);
      chk("t5_count_in_reset", int'(fifo_count0), 0);
      chk("t5_ready_in_reset", int'(in_ready0), 1);
      exp0.delete();
      exp1.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (!tx0 || busy0) hits++;
      end
      chk("t5_quiet_after_reset", hits, 0);
      done_cnt0 = 0;
      push(0, 9'h03C, w);
      wait_idle(0);
      chk("t5_frame_after_push", done_cnt0, 1);

      chk("queues_drained", exp0.size() + exp1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the single-byte fixed-format transmitter.
- Adds configurable data width and stop-bit count, an input FIFO with a valid/ready handshake, and back-to-back frames with no idle gap.
- Sits between a byte producer, such as a bus bridge or CPU register file, and the serial pin.
- The optional parity stage can be compiled in or out.

Parameters:
CLKS_PER_BIT, 8, clock cycles per serial bit; must be >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset (fixed: one clock, async active-low reset)
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_BITS  word to transmit
in_ready  output  1  FIFO can accept; equals !full
parity_mode  input  2  0 = none, 1 = even, 2 = odd, 3 = none; present only with the parity macro; sampled at frame start
tx  output  1  serial line, registered, idle high
busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - tx = 1, busy = 0, tx_done = 0, fifo_count = 0, in_ready = 1.
  - FSM goes to IDLE; FIFO pointers and all counters clear.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- Push: on a clock edge where in_valid && in_ready.
  - When full, in_ready = 0. A simultaneous pop does not allow a push that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, latch parity_mode, and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shreg[0] for CLKS_PER_BIT cycles per bit, shifting right.
    - bit_idx counts 0..DATA_BITS-1.
    - After the last bit, go to PARITY if enabled and the latched mode is 1 or 2; otherwise go to STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
    - Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
    - tx_done pulses on the final cycle.
    - If the FIFO is non-empty, pop and go straight to START (no IDLE cycle); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and produces a bit tick at CLKS_PER_BIT-1.
  - Resets to 0 on every state entry.
- Latency: for a word pushed into an empty FIFO while IDLE, tx falls on the edge after the push edge.
- Frame length, in cycles: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P is 0 or 1.
- in_data and parity_mode changes have no effect on a frame already in flight.
- fifo_count is updated on the edge of the push or pop. A simultaneous push and pop leaves it unchanged.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - The parity_mode port exists.
  - The PARITY state is reachable.
- Undefined:
  - The port is absent.
  - The PARITY state and its logic are not generated.
  - The frame is always start + data + stop.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - the parity_mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a helper function parity_bit(data, mode).
- Sub-module sync_fifo (params WIDTH, DEPTH) provides wr_en/din/rd_en/dout/full/empty/count, with an async active-low reset.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
1. Single word, CLKS_PER_BIT = 8, DATA_BITS = 8, STOP_BITS = 1, no parity; push 8'hB7.
   - tx falls 1 cycle after the push edge.
   - Bits sampled mid-bit are 0,1,1,1,0,1,1,0,1,1 (start, data LSB first, stop).
   - busy is high for 80 cycles; tx_done pulses once at cycle 80.
2. Burst: push 4 words (8'h00, 8'hFF, 8'h55, 8'hAA) on consecutive cycles.
   - in_ready drops after the 4th push only while the FIFO is full (the first word pops immediately).
   - The frames are contiguous, with no idle-high cycles between stop and the next start.
   - Total busy time is 320 cycles.
3. Parity (macro defined): parity_mode = 1 with 8'h07, then parity_mode = 2 with 8'h07.
   - Parity bit is 1 for the first frame and 0 for the second.
   - Each frame is 88 cycles.
4. DATA_BITS = 7, STOP_BITS = 2 instance; push 7'h41.
   - Frame is 1 + 7 + 2 = 10 bits (80 cycles).
   - The stop level is high for 16 cycles; tx_done fires at its end.
5. Reset mid-frame: drop reset_n during DATA bit 3 with 2 words queued.
   - tx = 1 and busy = 0 immediately, and fifo_count = 0.
   - After release, no frame starts until a new push arrives.
6. Full FIFO: hold in_valid while full, FIFO_DEPTH = 4.
   - No word is lost or duplicated; fifo_count never exceeds 4.
   - in_ready reasserts the cycle after a pop.
